fc_axis_receiver: RTL
=====================

# fc_axis_receiver

Upstream receive stage for the fully-connected core. It accepts a DMA AXI4-Stream of 32-bit words and writes them sequentially into the feature, bias or weight buffer, as selected by the APB-programmed `receiveCommand` and `receive_size`. When the programmed number of beats has been written, it raises the matching `*_receive_done` flag. It owns the S_AXIS slave handshake that the FC core and APB register block rely on, and it holds the written data stable for the FC datapath.

## Interface
- `DATA_WIDTH`, 32: stream and buffer word width.
- `ADDR_WIDTH`, 21: buffer address width; matches `receive_size`.

- `clk`, in, 1: single clock; every register is on the rising edge.
- `rstn`, in, 1: reset, asynchronous, active-low.
- `S_AXIS_TDATA`, in, DATA_WIDTH: stream data.
- `S_AXIS_TVALID`, in, 1: stream valid.
- `S_AXIS_TLAST`, in, 1: end-of-packet marker.
- `S_AXIS_TREADY`, out, 1: receiver ready.
- `receiveCommand`, in, 3: 0 idle, 1 feature, 2 bias, 3 weight; 4–7 reserved and ignored.
- `receive_size`, in, ADDR_WIDTH: number of words to receive.
- `buf_we`, out, 1: buffer write strobe.
- `buf_sel`, out, 2: target buffer; 1 feature, 2 bias, 3 weight.
- `buf_addr`, out, ADDR_WIDTH: word address, starting at 0.
- `buf_wdata`, out, DATA_WIDTH: write data.
- `feature_receive_done`, out, 1: feature load complete.
- `bias_receive_done`, out, 1: bias load complete.
- `weight_receive_done`, out, 1: weight load complete.
- `busy`, out, 1: high in RECV.
- `len_err`, out, 1: packet length mismatch (see Configuration).

## Operation
**States:** IDLE, RECV, DONE.
- **IDLE:**
  - When `receiveCommand` is 1, 2 or 3: latch the command into `cmd_r`, latch `receive_size` into `size_r`, clear `cnt`, clear `len_err`.
  - Next state is RECV if `size_r` is nonzero; otherwise DONE with no writes.
- **RECV:**
  - `S_AXIS_TREADY` = 1.
  - Each handshake (TVALID & TREADY) registers `buf_wdata` = TDATA, `buf_addr` = `cnt`, `buf_sel` = `cmd_r`, `buf_we` = 1, then increments `cnt`.
  - When the beat with `cnt` == `size_r`-1 is accepted, go to DONE.
- **DONE:**
  - The done flag for `cmd_r` is high; the other two stay low.
  - Hold until `receiveCommand` == 0, then return to IDLE and clear the flag. Level-held commands therefore never retrigger.
- Changes to `receiveCommand` or `receive_size` during RECV/DONE are ignored; the latched values apply.
- Beats offered in IDLE/DONE are not accepted (TREADY = 0).
- TLAST with FC_RX_LEN_CHECK_EN undefined: ignored; the transfer length is set only by `size_r`.
- Counter arithmetic: `cnt` is ADDR_WIDTH bits and never wraps, because `size_r` is at most 2^ADDR_WIDTH-1.

## Timing
**Reset values:** TREADY, `buf_we`, `buf_sel`, `buf_addr`, `buf_wdata`, all done flags, `busy` and `len_err` are 0. State is IDLE.

**Latencies:**
- Command present in IDLE at cycle C: `busy` and TREADY are high from C+1.
- Beat accepted at cycle N: `buf_we`/`buf_addr`/`buf_wdata` are valid during N+1, for one cycle per beat.
- Final beat accepted at N: done flag is high from N+2, one cycle after the final write.
- `size_r` = 0: done is high at C+2.

**Throughput:** one beat per cycle while TVALID is held. TVALID gaps insert no writes.

**TREADY:** combinational from state (RECV only), independent of TVALID. It drops in the cycle after the final accept.

**Reset mid-transfer:** immediate return to IDLE with all outputs cleared. Partial buffer contents are undefined; the stream source must be reset too.

## Configuration
- **`FC_RX_LEN_CHECK_EN` defined:**
  - TLAST on a beat with `cnt` < `size_r`-1: accept and write that beat, set `len_err`, go to DONE.
  - Final beat without TLAST: set `len_err`, still go to DONE.
  - `len_err` is held until the next command latch.
- **`FC_RX_LEN_CHECK_EN` undefined:** TLAST is unused and `len_err` is tied to 0.

## Test plan
- **Feature load:** `receiveCommand`=1, `receive_size`=4, continuous beats 0xA0..0xA3 with TLAST on the 4th -> writes at addr 0..3 with `buf_sel`=1, `feature_receive_done` high 2 cycles after the last accept, TREADY low afterwards; `receiveCommand`←0 -> flag clears the next cycle.
- **Weight load with backpressure:** `receiveCommand`=3, size 3, TVALID toggled 1,0,1,0,1 -> exactly 3 writes at addr 0,1,2; `weight_receive_done` asserted; the bias and feature flags stay 0.
- **Zero size:** `receiveCommand`=2, `receive_size`=0 -> no `buf_we`, `bias_receive_done` high at C+2, TREADY never high.
- **Early TLAST (LEN_CHECK on):** size 8, TLAST on beat 5 -> 5 writes, `len_err`=1, done high; macro off -> TLAST ignored, 8 writes, `len_err`=0.
- **Reset mid-transfer:** `rstn` low after 2 of 6 beats -> all outputs 0 asynchronously; a new feature command of size 2 then completes normally from addr 0.

Source files
------------

// File: rtl/fc_axis_receiver_if.sv
// AXI4-Stream slave bundle between the DMA engine and fc_axis_receiver.
// The DMA engine drives data/valid/last; the receiver answers with ready.
interface fc_axis_receiver_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] S_AXIS_TDATA;
    logic                  S_AXIS_TVALID;
    logic                  S_AXIS_TLAST;
    logic                  S_AXIS_TREADY;

    modport master (
        output S_AXIS_TDATA,
        output S_AXIS_TVALID,
        output S_AXIS_TLAST,
        input  S_AXIS_TREADY
    );

    modport slave (
        input  S_AXIS_TDATA,
        input  S_AXIS_TVALID,
        input  S_AXIS_TLAST,
        output S_AXIS_TREADY
    );
endinterface

// File: rtl/fc_axis_receiver.sv
// Receive stage for the FC core: streams DMA words into the feature/bias/weight buffer.
// Define FC_RX_LEN_CHECK_EN to compare TLAST against the programmed size and flag len_err.
module fc_axis_receiver #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 21
) (
    input  logic                  clk,
    input  logic                  rstn,
    fc_axis_receiver_if.slave     s_axis,
    input  logic [2:0]            receiveCommand,
    input  logic [ADDR_WIDTH-1:0] receive_size,
    output logic                  buf_we,
    output logic [1:0]            buf_sel,
    output logic [ADDR_WIDTH-1:0] buf_addr,
    output logic [DATA_WIDTH-1:0] buf_wdata,
    output logic                  feature_receive_done,
    output logic                  bias_receive_done,
    output logic                  weight_receive_done,
    output logic                  busy,
    output logic                  len_err
);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DONE
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [1:0]            cmd_r;
    logic [ADDR_WIDTH-1:0] size_r;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  cmd_ok;
    logic                  latch_cmd;
    logic                  accept;
    logic                  final_beat;
    logic                  tready;
    logic                  hold_done;
`ifdef FC_RX_LEN_CHECK_EN
    logic                  err_set;
`else
    logic                  unused_tlast;
`endif

    assign cmd_ok = (receiveCommand == 3'd1) || (receiveCommand == 3'd2) ||
                    (receiveCommand == 3'd3);
    assign final_beat = (cnt == size_r - 1'b1);
    assign s_axis.S_AXIS_TREADY = tready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        latch_cmd  = 1'b0;
        accept     = 1'b0;
        tready     = 1'b0;
        busy       = 1'b0;
`ifdef FC_RX_LEN_CHECK_EN
        err_set    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (cmd_ok) begin
                    latch_cmd  = 1'b1;
                    state_next = (receive_size != '0) ? RECV : DONE;
                end
            end
            RECV: begin
                tready = 1'b1;
                busy   = 1'b1;
                if (s_axis.S_AXIS_TVALID) begin
                    accept = 1'b1;
`ifdef FC_RX_LEN_CHECK_EN
                    // Either a short packet or a missing TLAST ends the transfer with an error.
                    if (final_beat) begin
                        state_next = DONE;
                        err_set    = !s_axis.S_AXIS_TLAST;
                    end else if (s_axis.S_AXIS_TLAST) begin
                        state_next = DONE;
                        err_set    = 1'b1;
                    end
`else
                    if (final_beat) begin
                        state_next = DONE;
                    end
`endif
                end
            end
            DONE: begin
                if (receiveCommand == 3'd0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Done flags rise one cycle into DONE and drop on the same edge that returns to IDLE.
    assign hold_done = (state == DONE) && (receiveCommand != 3'd0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cmd_r                <= 2'd0;
            size_r               <= '0;
            cnt                  <= '0;
            buf_we               <= 1'b0;
            buf_sel              <= 2'd0;
            buf_addr             <= '0;
            buf_wdata            <= '0;
            feature_receive_done <= 1'b0;
            bias_receive_done    <= 1'b0;
            weight_receive_done  <= 1'b0;
        end else begin
            buf_we <= accept;
            if (latch_cmd) begin
                cmd_r  <= receiveCommand[1:0];
                size_r <= receive_size;
                cnt    <= '0;
            end else if (accept) begin
                cnt <= cnt + 1'b1;
            end
            if (accept) begin
                buf_wdata <= s_axis.S_AXIS_TDATA;
                buf_addr  <= cnt;
                buf_sel   <= cmd_r;
            end
            feature_receive_done <= hold_done && (cmd_r == 2'd1);
            bias_receive_done    <= hold_done && (cmd_r == 2'd2);
            weight_receive_done  <= hold_done && (cmd_r == 2'd3);
        end
    end

`ifdef FC_RX_LEN_CHECK_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len_err <= 1'b0;
        end else if (latch_cmd) begin
            len_err <= 1'b0;
        end else if (err_set) begin
            len_err <= 1'b1;
        end
    end
`else
    assign unused_tlast = s_axis.S_AXIS_TLAST;
    assign len_err      = 1'b0;
`endif

endmodule
